// File: rtl/traffic_density_sel_pkg.sv
// Shared types and default constants for the traffic density selector.
// The tr_sel_e encoding is consumed by the signal control unit, which maps
// LOW to red 30 / green 10, HIGH to red 10 / green 30 and NORMAL to 20 / 20.
package traffic_pkg;

  typedef enum logic [1:0] {
    TR_NORMAL = 2'b00,
    TR_LOW    = 2'b01,
    TR_HIGH   = 2'b10
  } tr_sel_e;

  // Default build: 320x240 frame, thresholds in vehicle pixels per frame.
  localparam int TR_CNT_W       = 17;
  localparam int TR_TH_LOW      = 2000;
  localparam int TR_TH_HIGH     = 8000;
  localparam int TR_HYST_FRAMES = 3;

  // Map a completed frame count onto a flow class. HIGH wins when the two
  // thresholds are equal, which makes NORMAL unreachable in that build.
  function automatic tr_sel_e tr_classify(
    input logic [31:0] count,
    input logic [31:0] th_low,
    input logic [31:0] th_high
  );
    tr_sel_e cls;
    if (count >= th_high) begin
      cls = TR_HIGH;
    end else if (count < th_low) begin
      cls = TR_LOW;
    end else begin
      cls = TR_NORMAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/traffic_density_sel_if.sv
// Pixel-stream inputs and committed-class outputs of the density selector.
// slave: the selector itself; master: the video source / consumer side.
interface traffic_density_sel_if #(
  parameter int CNT_W = 17
);
  import traffic_pkg::*;

  logic             i_vsync;
  logic             i_de;
  logic             i_roi;
  logic             i_car_px;
  logic [CNT_W-1:0] o_density;
  tr_sel_e          o_traffic_sel;
  logic             o_sel_valid;

  modport slave (
    input  i_vsync, i_de, i_roi, i_car_px,
    output o_density, o_traffic_sel, o_sel_valid
  );

  modport master (
    output i_vsync, i_de, i_roi, i_car_px,
    input  o_density, o_traffic_sel, o_sel_valid
  );

endinterface

// File: rtl/traffic_density_sel_hyst.sv
// Frame-count hysteresis: a new class is committed only after HYST_FRAMES
// consecutive identical raw classifications, which rejects flicker.
module density_hysteresis
  import traffic_pkg::*;
#(
  parameter int HYST_FRAMES = TR_HYST_FRAMES
) (
  input  logic    clk,
  input  logic    reset,
  input  tr_sel_e raw_class,
  input  logic    class_vld,
  output tr_sel_e o_traffic_sel,
  output logic    o_sel_valid
);

  localparam logic [3:0] HYST_MAX = 4'(HYST_FRAMES);

  tr_sel_e    cand_r;
  tr_sel_e    cand_next_s;
  logic [3:0] streak_r;
  logic [3:0] streak_next_s;
  tr_sel_e    sel_r;
  logic       sel_valid_r;
  logic       commit_s;

  // Next candidate/streak and commit decision for the frame being classified.
  always_comb begin
    cand_next_s   = cand_r;
    streak_next_s = streak_r;
    commit_s      = 1'b0;
    if (class_vld) begin
      if (raw_class == cand_r) begin
        if (streak_r >= HYST_MAX) begin
          streak_next_s = HYST_MAX;
        end else begin
          streak_next_s = streak_r + 4'd1;
        end
      end else begin
        cand_next_s   = raw_class;
        streak_next_s = 4'd1;
      end
      commit_s = (streak_next_s == HYST_MAX) && (cand_next_s != sel_r);
    end else begin
      commit_s = 1'b0;
    end
  end

  // Hold candidate, streak, committed class and the one-cycle change strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_r      <= TR_NORMAL;
      streak_r    <= 4'd0;
      sel_r       <= TR_NORMAL;
      sel_valid_r <= 1'b0;
    end else begin
      cand_r      <= cand_next_s;
      streak_r    <= streak_next_s;
      sel_valid_r <= commit_s;
      if (commit_s) begin
        sel_r <= cand_next_s;
      end else begin
        sel_r <= sel_r;
      end
    end
  end

  assign o_traffic_sel = sel_r;
  assign o_sel_valid   = sel_valid_r;

endmodule

// File: rtl/traffic_density_sel.sv
// Counts vehicle pixels inside the ROI per frame, classifies each completed
// frame against two thresholds and hands the class to the hysteresis filter.
// The first vsync after reset only arms the block: the partial frame seen
// since reset is not a real measurement.
module traffic_density_sel
  import traffic_pkg::*;
#(
  parameter int CNT_W       = TR_CNT_W,
  parameter int TH_LOW      = TR_TH_LOW,
  parameter int TH_HIGH     = TR_TH_HIGH,
  parameter int HYST_FRAMES = TR_HYST_FRAMES
) (
  input  logic                  clk,
  input  logic                  reset,
  traffic_density_sel_if.slave  bus
);

  localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ACC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             qual_s;
  logic [CNT_W-1:0] acc_r;
  logic [CNT_W-1:0] acc_next_s;
  logic             frame_started_r;
  logic [CNT_W-1:0] density_r;
  tr_sel_e          raw_class_r;
  tr_sel_e          raw_next_s;
  logic             class_vld_r;

  assign qual_s = bus.i_de & bus.i_roi & bus.i_car_px;

  // Saturating accumulator; a pixel coincident with vsync opens the new frame.
  always_comb begin
    acc_next_s = acc_r;
    if (bus.i_vsync) begin
      if (qual_s) begin
        acc_next_s = ACC_ONE;
      end else begin
        acc_next_s = {CNT_W{1'b0}};
      end
    end else if (qual_s && (acc_r != ACC_MAX)) begin
      acc_next_s = acc_r + ACC_ONE;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Threshold compare on the count of the frame that is closing.
  always_comb begin
    raw_next_s = tr_classify(32'(acc_r), 32'(TH_LOW), 32'(TH_HIGH));
  end

  // Frame bookkeeping: arm on first vsync, latch count and class afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r           <= {CNT_W{1'b0}};
      frame_started_r <= 1'b0;
      density_r       <= {CNT_W{1'b0}};
      raw_class_r     <= TR_NORMAL;
      class_vld_r     <= 1'b0;
    end else begin
      acc_r <= acc_next_s;
      if (bus.i_vsync && !frame_started_r) begin
        frame_started_r <= 1'b1;
        class_vld_r     <= 1'b0;
      end else if (bus.i_vsync) begin
        density_r   <= acc_r;
        raw_class_r <= raw_next_s;
        class_vld_r <= 1'b1;
      end else begin
        class_vld_r <= 1'b0;
      end
    end
  end

  assign bus.o_density = density_r;

  density_hysteresis #(
    .HYST_FRAMES (HYST_FRAMES)
  ) u_hyst (
    .clk           (clk),
    .reset         (reset),
    .raw_class     (raw_class_r),
    .class_vld     (class_vld_r),
    .o_traffic_sel (bus.o_traffic_sel),
    .o_sel_valid   (bus.o_sel_valid)
  );

endmodule

// File: tb/tb_traffic_density_sel.sv
// Self-checking bench for traffic_density_sel. A behavioural frame model
// pushes the expected density/class/strobe at every vsync; the scenario
// tasks pop and compare at the cycles the outputs are due.
module tb_traffic_density_sel;
  import traffic_pkg::*;

  typedef struct {
    logic [16:0] dens;
    logic [1:0]  sel;
    logic        vld;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  traffic_density_sel_if #(.CNT_W(17)) bus ();
  traffic_density_sel_if #(.CNT_W(8))  bus8 ();

  assign bus8.i_vsync  = bus.i_vsync;
  assign bus8.i_de     = bus.i_de;
  assign bus8.i_roi    = bus.i_roi;
  assign bus8.i_car_px = bus.i_car_px;

  traffic_density_sel #(.CNT_W(17), .TH_LOW(2000), .TH_HIGH(8000), .HYST_FRAMES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  traffic_density_sel #(.CNT_W(8), .TH_LOW(100), .TH_HIGH(200), .HYST_FRAMES(3)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  // Reference model state; classes coded 0 NORMAL, 1 LOW, 2 HIGH.
  bit   m_armed;
  int   m_acc;
  int   m_dens;
  int   m_cand;
  int   m_streak;
  int   m_sel;

  task automatic model_reset();
    m_armed  = 1'b0;
    m_acc    = 0;
    m_dens   = 0;
    m_cand   = 0;
    m_streak = 0;
    m_sel    = 0;
    sb_q.delete();
  endtask

  task automatic apply(input bit vs, input bit de, input bit roi, input bit car);
    exp_t e;
    bit   q;
    int   rc;
    bus.i_vsync  = vs;
    bus.i_de     = de;
    bus.i_roi    = roi;
    bus.i_car_px = car;
    q = de & roi & car;
    if (vs) begin
      e.vld = 1'b0;
      if (!m_armed) begin
        m_armed = 1'b1;
      end else begin
        m_dens = m_acc;
        if (m_acc >= 8000) rc = 2;
        else if (m_acc < 2000) rc = 1;
        else rc = 0;
        if (rc == m_cand) begin
          if (m_streak < 3) m_streak++;
        end else begin
          m_cand   = rc;
          m_streak = 1;
        end
        if (m_streak == 3 && m_cand != m_sel) begin
          m_sel = m_cand;
          e.vld = 1'b1;
        end
      end
      e.dens = 17'(m_dens);
      e.sel  = 2'(m_sel);
      sb_q.push_back(e);
      m_acc = q ? 1 : 0;
    end else if (q && m_acc < 131071) begin
      m_acc++;
    end
  endtask

  task automatic drive(input bit vs, input bit de, input bit roi, input bit car);
    @(negedge clk);
    apply(vs, de, roi, car);
  endtask

  task automatic set_idle();
    bus.i_vsync  = 1'b0;
    bus.i_de     = 1'b0;
    bus.i_roi    = 1'b0;
    bus.i_car_px = 1'b0;
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  // Close a frame with vsync and check density at N+1, class/strobe at N+2.
  task automatic end_frame(input string tag, input bit vpx);
    exp_t e;
    drive(1'b1, vpx, vpx, vpx);
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue, expected one entry", tag);
      return;
    end
    e = sb_q.pop_front();
    @(negedge clk);
    checks++;
    if (bus.o_density !== e.dens) begin
      errors++;
      $display("FAIL %s density: got %0d expected %0d", tag, bus.o_density, e.dens);
    end
    checks++;
    if (bus.o_sel_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_strobe: got %b expected 0", tag, bus.o_sel_valid);
    end
    set_idle();
    @(negedge clk);
    checks++;
    if (bus.o_traffic_sel !== e.sel) begin
      errors++;
      $display("FAIL %s sel: got %b expected %b", tag, bus.o_traffic_sel, e.sel);
    end
    checks++;
    if (bus.o_sel_valid !== e.vld) begin
      errors++;
      $display("FAIL %s strobe: got %b expected %b", tag, bus.o_sel_valid, e.vld);
    end
    @(negedge clk);
    checks++;
    if (bus.o_sel_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s late_strobe: got %b expected 0", tag, bus.o_sel_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_idle();
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_density !== 17'd0) begin
      errors++;
      $display("FAIL reset_density: got %0d expected 0", bus.o_density);
    end
    checks++;
    if (bus.o_traffic_sel !== 2'b00) begin
      errors++;
      $display("FAIL reset_sel: got %b expected 00", bus.o_traffic_sel);
    end
    checks++;
    if (bus.o_sel_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobe: got %b expected 0", bus.o_sel_valid);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_frame();
    end_frame("arm", 1'b0);
    pixels(100);
    end_frame("f100", 1'b0);
    checks++;
    if (bus.o_density !== 17'd100) begin
      errors++;
      $display("FAIL f100_const: got %0d expected 100", bus.o_density);
    end
  endtask

  task automatic test_high_commit();
    for (int f = 0; f < 4; f++) begin
      pixels(9000);
      end_frame($sformatf("high%0d", f), 1'b0);
    end
    checks++;
    if (bus.o_traffic_sel !== 2'b10) begin
      errors++;
      $display("FAIL high_const: got %b expected 10", bus.o_traffic_sel);
    end
  endtask

  task automatic test_midframe_reset();
    pixels(500);
    @(negedge clk);
    set_idle();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.o_density !== 17'd0) begin
      errors++;
      $display("FAIL async_density: got %0d expected 0", bus.o_density);
    end
    checks++;
    if (bus.o_traffic_sel !== 2'b00) begin
      errors++;
      $display("FAIL async_sel: got %b expected 00", bus.o_traffic_sel);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    pixels(40);
    end_frame("post_rst_arm", 1'b0);
    pixels(10);
    end_frame("post_rst_f10", 1'b0);
  endtask

  task automatic test_flicker();
    int counts[4] = '{9000, 5000, 9000, 5000};
    for (int f = 0; f < 4; f++) begin
      pixels(counts[f]);
      end_frame($sformatf("flick%0d", f), 1'b0);
    end
    checks++;
    if (bus.o_traffic_sel !== 2'b00) begin
      errors++;
      $display("FAIL flicker_const: got %b expected 00", bus.o_traffic_sel);
    end
  endtask

  task automatic test_vsync_pixel();
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
    end
    end_frame("f50", 1'b1);
    checks++;
    if (bus.o_density !== 17'd50) begin
      errors++;
      $display("FAIL f50_const: got %0d expected 50", bus.o_density);
    end
    pixels(20);
    end_frame("f21", 1'b0);
    checks++;
    if (bus.o_density !== 17'd21) begin
      errors++;
      $display("FAIL f21_const: got %0d expected 21", bus.o_density);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e1;
    exp_t e2;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    e1 = sb_q.pop_front();
    checks++;
    if (bus.o_density !== e1.dens) begin
      errors++;
      $display("FAIL b2b1_density: got %0d expected %0d", bus.o_density, e1.dens);
    end
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    e2 = sb_q.pop_front();
    @(negedge clk);
    set_idle();
    checks++;
    if (bus.o_traffic_sel !== e1.sel || bus.o_sel_valid !== e1.vld) begin
      errors++;
      $display("FAIL b2b1_sel: got %b/%b expected %b/%b", bus.o_traffic_sel, bus.o_sel_valid, e1.sel, e1.vld);
    end
    checks++;
    if (bus.o_density !== e2.dens) begin
      errors++;
      $display("FAIL b2b2_density: got %0d expected %0d", bus.o_density, e2.dens);
    end
    @(negedge clk);
    checks++;
    if (bus.o_traffic_sel !== e2.sel || bus.o_sel_valid !== e2.vld) begin
      errors++;
      $display("FAIL b2b2_sel: got %b/%b expected %b/%b", bus.o_traffic_sel, bus.o_sel_valid, e2.sel, e2.vld);
    end
    checks++;
    if (bus.o_traffic_sel !== 2'b01) begin
      errors++;
      $display("FAIL b2b_low_const: got %b expected 01", bus.o_traffic_sel);
    end
  endtask

  task automatic test_saturation();
    pixels(300);
    end_frame("sat300", 1'b0);
    checks++;
    if (bus8.o_density !== 8'd255) begin
      errors++;
      $display("FAIL sat_density8: got %0d expected 255", bus8.o_density);
    end
    pixels(20);
    end_frame("sat20", 1'b0);
    checks++;
    if (bus8.o_density !== 8'd20) begin
      errors++;
      $display("FAIL small_density8: got %0d expected 20", bus8.o_density);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_first_frame();
    test_high_commit();
    test_midframe_reset();
    test_flicker();
    test_vsync_pixel();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_density_sel.md
Name: traffic_density_sel

Overview:
- Produces the `traffic_sel` input that the signal control unit consumes: the upstream end of that interface.
- Counts vehicle-classified pixels inside a region of interest (ROI) for each video frame from the camera/image-processing path.
- Classifies each completed frame as LOW, NORMAL or HIGH traffic flow, filters the result with frame-count hysteresis, and drives a stable `o_traffic_sel` plus a change strobe.

Parameters:
- CNT_W, 17, width of the per-frame pixel counter (covers 320x240 = 76800 pixels).
- TH_LOW, 2000, a frame count below this value classifies as LOW.
- TH_HIGH, 8000, a frame count at or above this value classifies as HIGH.
- HYST_FRAMES, 3, number of consecutive identical classifications required to change the output (range 1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- i_vsync  input  1  frame-boundary pulse, active-high, 1 cycle.
- i_de  input  1  pixel valid.
- i_roi  input  1  current pixel lies inside the ROI.
- i_car_px  input  1  current pixel is classified as vehicle.
- o_density  output  CNT_W  vehicle-pixel count of the last completed frame.
- o_traffic_sel  output  2  committed flow class: 00 NORMAL, 01 LOW, 10 HIGH. 11 is never driven.
- o_sel_valid  output  1  1-cycle pulse in the cycle `o_traffic_sel` takes a new value.

Behaviour:
- Reset (reset=0, async) forces:
  - o_density=0, o_traffic_sel=NORMAL, o_sel_valid=0.
  - Accumulator=0, raw_class=NORMAL, candidate=NORMAL, streak=0, frame_started=0, class_vld=0.
- Accumulation:
  - The accumulator increments on each cycle where i_de & i_roi & i_car_px = 1.
  - It saturates at 2^CNT_W-1 and never wraps.
- Frame boundary (i_vsync=1 in cycle N):
  - If frame_started=0, the partial frame since reset is discarded. Set frame_started=1, clear the accumulator, and do no classification.
  - Otherwise, in cycle N+1:
    - o_density = accumulator value, including any qualifying pixel in cycle N-1 but not cycle N.
    - raw_class = HIGH if count >= TH_HIGH; LOW if count < TH_LOW; NORMAL otherwise.
    - class_vld is pulsed.
  - Accumulator restart: if a qualifying pixel coincides with i_vsync, the accumulator restarts at 1 (that pixel belongs to the new frame); otherwise it restarts at 0.
- Hysteresis, evaluated in the cycle class_vld=1, with results registered at N+2:
  - If raw_class == candidate: streak = min(streak+1, HYST_FRAMES).
  - Otherwise: candidate = raw_class and streak = 1.
  - If the resulting streak == HYST_FRAMES and candidate != o_traffic_sel:
    - o_traffic_sel = candidate.
    - o_sel_valid = 1 for exactly one cycle (N+2).
- Latency: vsync to o_density is 1 cycle; vsync to o_traffic_sel/o_sel_valid is 2 cycles.
- Flicker rejection: an alternating pattern (e.g. HIGH, NORMAL, HIGH, ...) never reaches HYST_FRAMES and never changes the output.
- HYST_FRAMES=1: every frame whose class differs from the current output commits immediately.
- Back-to-back vsync (empty frame, count 0) is legal and classifies as LOW.
- A second i_vsync arriving while class_vld is pending: the pipeline handles one frame per cycle, so no frame is dropped.
- Reset asserted mid-frame: all state is cleared. The first vsync after release only arms the block (frame_started).
- Parameter requirement: TH_LOW <= TH_HIGH. If they are equal, NORMAL is unreachable; this is legal.

Decomposition:
- Shared package traffic_pkg holds:
  - typedef enum logic [1:0] tr_sel_e {TR_NORMAL=2'b00, TR_LOW=2'b01, TR_HIGH=2'b10}.
  - Default threshold constants TR_TH_LOW and TR_TH_HIGH.
- These encodings must match the signal control unit's duration selection: LOW = red 30 / green 10, HIGH = red 10 / green 30, NORMAL = 20 / 20.
- One natural sub-module, density_hysteresis:
  - Inputs: raw_class and class_vld.
  - Contents: candidate/streak registers.
  - Outputs: o_traffic_sel and o_sel_valid.
- The top level holds the accumulator, frame_started and the threshold compare.

Test Plan:
1. Reset, then vsync, 100 qualifying pixels, vsync: first vsync only arms; second gives o_density=100 at N+1, no o_sel_valid (LOW streak=1 only), o_traffic_sel stays 00.
2. Three consecutive frames of 9000 qualifying pixels (TH_HIGH=8000, HYST_FRAMES=3): o_traffic_sel=10 with a single o_sel_valid pulse 2 cycles after the third-frame vsync; a fourth identical frame produces no pulse.
3. Frames with counts 9000, 5000, 9000, 5000 starting from NORMAL: o_traffic_sel stays 00 and o_sel_valid is never asserted.
4. Qualifying pixel presented in the same cycle as vsync, after a frame of 50 pixels: o_density=50 and the next frame's count includes that pixel (next o_density = 1 + later pixels). Pixels with i_roi=0 or i_de=0 are not counted.
5. CNT_W=8 build with 300 qualifying pixels in one frame: o_density=255 (saturated, no wrap).
6. After HIGH is committed, assert reset mid-frame: o_traffic_sel=00, o_density=0 immediately (async), and the first post-reset vsync produces no classification.
